park_code_decoder: RTL and testbench

//  Exit-side counterpart of the place-code generator: accepts a 4-bit exit code, decodes it
//  to place index P = 15 - code (= ~code), checks it against the 16-place occupancy map and

---
 rtl/park_code_decoder_if.sv | 29 ++
 rtl/park_code_decoder.sv | 125 ++++++++++++
 tb/tb_park_code_decoder.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/park_code_decoder_if.sv
// Exit-terminal bus for park_code_decoder: keypad code handshake, entry-side
// occupancy set port and the decode/gate/status outputs.
interface park_code_decoder_if;
   logic        code_valid;
   logic [3:0]  code_in;
   logic        code_ready;
   logic        occ_set_valid;
   logic [3:0]  occ_set_place;
   logic        occ_set_err;
   logic        result_valid;
   logic        result_ok;
   logic [3:0]  place_out;
   logic        gate_open;
   logic        locked;
   logic [15:0] occupancy;
   logic [4:0]  free_count;

   modport master (
      output code_valid, code_in, occ_set_valid, occ_set_place,
      input  code_ready, occ_set_err, result_valid, result_ok, place_out,
             gate_open, locked, occupancy, free_count
   );

   modport slave (
      input  code_valid, code_in, occ_set_valid, occ_set_place,
      output code_ready, occ_set_err, result_valid, result_ok, place_out,
             gate_open, locked, occupancy, free_count
   );
endinterface

// File: rtl/park_code_decoder.sv
// Exit-side place-code decoder: decodes code to place ~code, frees an occupied
// place and opens the gate, locks the terminal after MAX_FAILS bad codes in a row.
module park_code_decoder #(
   parameter int unsigned GATE_CYCLES = 3000,
   parameter int unsigned MAX_FAILS   = 3,
   parameter int unsigned LOCK_CYCLES = 10000
) (
   input logic               clk,
   input logic               rst_n,
   park_code_decoder_if.slave bus
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_CHECK  = 3'd2;
   localparam logic [2:0] S_GATE   = 3'd3;
   localparam logic [2:0] S_LOCK   = 3'd4;

   localparam int unsigned TMAX = (GATE_CYCLES > LOCK_CYCLES) ? GATE_CYCLES : LOCK_CYCLES;
   localparam int unsigned TW   = $clog2(TMAX + 1);

   logic [2:0]    state_q, state_d;
   logic [3:0]    code_q;
   logic [3:0]    place_q;
   logic [2:0]    fail_q, fail_d;
   logic [2:0]    fail_inc;
   logic [TW-1:0] tmr_q, tmr_d;
   logic [15:0]   occ_q, occ_d;
   logic [4:0]    free_q, free_d;
   logic          set_err_q, set_err_d;
   logic          hit;

   assign hit      = occ_q[place_q];
   assign fail_inc = fail_q + 3'd1;

   always_comb begin
      state_d = state_q;
      fail_d  = fail_q;
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE:   if (bus.code_valid) state_d = S_DECODE;
         S_DECODE: state_d = S_CHECK;
         S_CHECK: begin
            if (hit) begin
               fail_d  = '0;
               tmr_d   = TW'(GATE_CYCLES - 1);
               state_d = S_GATE;
            end else begin
               fail_d = fail_inc;
               if (fail_inc == 3'(MAX_FAILS)) begin
                  tmr_d   = TW'(LOCK_CYCLES - 1);
                  state_d = S_LOCK;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         S_GATE: begin
            if (tmr_q == '0) state_d = S_IDLE;
            else             tmr_d   = tmr_q - 1'b1;
         end
         S_LOCK: begin
            if (tmr_q == '0) begin
               state_d = S_IDLE;
               fail_d  = '0;
            end else begin
               tmr_d = tmr_q - 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // A set on the place being freed hits an occupied bit, so the clear wins
   // and the set is reported as an error without extra arbitration.
   always_comb begin
      occ_d     = occ_q;
      set_err_d = 1'b0;
      if (state_q == S_CHECK && hit) occ_d[place_q] = 1'b0;
      if (bus.occ_set_valid) begin
         if (occ_q[bus.occ_set_place]) set_err_d = 1'b1;
         else                          occ_d[bus.occ_set_place] = 1'b1;
      end
   end

   always_comb begin
      free_d = 5'd16;
      for (int unsigned i = 0; i < 16; i++) begin
         free_d = free_d - {4'd0, occ_d[i]};
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         code_q    <= '0;
         place_q   <= '0;
         fail_q    <= '0;
         tmr_q     <= '0;
         occ_q     <= '0;
         free_q    <= 5'd16;
         set_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         fail_q    <= fail_d;
         tmr_q     <= tmr_d;
         occ_q     <= occ_d;
         free_q    <= free_d;
         set_err_q <= set_err_d;
         if (state_q == S_IDLE && bus.code_valid) code_q <= bus.code_in;
         if (state_q == S_DECODE)                 place_q <= ~code_q;
      end
   end

   assign bus.code_ready   = (state_q == S_IDLE);
   assign bus.result_valid = (state_q == S_CHECK);
   assign bus.result_ok    = (state_q == S_CHECK) && hit;
   assign bus.place_out    = place_q;
   assign bus.gate_open    = (state_q == S_GATE);
   assign bus.locked       = (state_q == S_LOCK);
   assign bus.occupancy    = occ_q;
   assign bus.free_count   = free_q;
   assign bus.occ_set_err  = set_err_q;

endmodule

// File: tb/tb_park_code_decoder.sv
// Scoreboard bench for park_code_decoder: expected decode results are queued
// when a code is accepted and checked when result_valid appears.
module tb_park_code_decoder;

   typedef struct packed {
      logic [3:0] place;
      logic       ok;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   n_vec = 0;
   int   n_err = 0;
   exp_t sb[$];
   logic [15:0] occ_m = '0;
   int   fail_m = 0;

   park_code_decoder_if bus();

   park_code_decoder #(
      .GATE_CYCLES(3000),
      .MAX_FAILS  (3),
      .LOCK_CYCLES(10000)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] free_m();
      return 32'(16 - $countones(occ_m));
   endfunction

   // result checker: one pop per result_valid cycle
   always @(posedge clk) begin
      #1;
      if (bus.result_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_depth", sb.size(), 1);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("place_out", bus.place_out, e.place);
            chk("result_ok", bus.result_ok, e.ok);
         end
      end
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (bus.code_ready !== 1'b1 && n < 20000) begin
         tick();
         n++;
      end
      if (n >= 20000) chk("ready_timeout", n, 0);
   endtask

   task automatic occ_set(input logic [3:0] p, input logic exp_err);
      bus.occ_set_valid = 1'b1;
      bus.occ_set_place = p;
      tick();
      bus.occ_set_valid = 1'b0;
      occ_m[p] = 1'b1;
      chk("occ_set_err", bus.occ_set_err, exp_err);
      chk("occ_bit", bus.occupancy[p], 1);
      chk("free_count", bus.free_count, free_m());
   endtask

   // returns at the sample just after the accepting edge
   task automatic send_code(input logic [3:0] c);
      exp_t e;
      logic [3:0] p;
      wait_ready();
      bus.code_valid = 1'b1;
      bus.code_in    = c;
      tick();
      bus.code_valid = 1'b0;
      p = ~c;
      e.place = p;
      e.ok    = occ_m[p];
      if (e.ok) begin
         occ_m[p] = 1'b0;
         fail_m = 0;
      end else begin
         fail_m++;
         if (fail_m == 3) fail_m = 0;
      end
      sb.push_back(e);
      chk("ready_low_after_accept", bus.code_ready, 0);
   endtask

   initial begin
      int n;
      bus.code_valid    = 1'b0;
      bus.code_in       = '0;
      bus.occ_set_valid = 1'b0;
      bus.occ_set_place = '0;
      #12;
      chk("rst_occupancy", bus.occupancy, 0);
      chk("rst_free_count", bus.free_count, 16);
      chk("rst_gate", bus.gate_open, 0);
      chk("rst_locked", bus.locked, 0);
      rst_n = 1'b1;
      tick();
      chk("rst_place_out", bus.place_out, 0);
      chk("rst_code_ready", bus.code_ready, 1);

      // good code frees place 5 and opens the gate for 3000 cycles
      occ_set(4'd5, 1'b0);
      send_code(4'b1010);
      tick();
      chk("t1_result_valid", bus.result_valid, 1);
      tick();
      chk("t1_occ5_cleared", bus.occupancy[5], 0);
      chk("t1_free_count", bus.free_count, 16);
      n = 0;
      while (bus.gate_open === 1'b1 && n < 5000) begin
         n++;
         tick();
      end
      chk("t1_gate_cycles", n, 3000);
      chk("t1_ready_after_gate", bus.code_ready, 1);

      // bad code on free place 15
      send_code(4'b0000);
      tick();
      tick();
      chk("t2_no_gate", bus.gate_open, 0);
      chk("t2_back_idle", bus.code_ready, 1);

      // bad, good clears the fail count; two more bads do not lock
      send_code(4'b0001);
      wait_ready();
      occ_set(4'd7, 1'b0);
      send_code(4'b1000);
      tick();
      tick();
      chk("t4_gate", bus.gate_open, 1);
      wait_ready();
      send_code(4'b0010);
      wait_ready();
      send_code(4'b0011);
      tick();
      tick();
      chk("t4_no_lock", bus.locked, 0);
      chk("t4_ready", bus.code_ready, 1);

      // third consecutive bad code locks; codes offered during lock are ignored
      send_code(4'b0100);
      tick();
      tick();
      chk("t3_locked", bus.locked, 1);
      chk("t3_ready_low", bus.code_ready, 0);
      n = 0;
      while (bus.locked === 1'b1 && n < 20000) begin
         bus.code_valid = (n < 10);
         bus.code_in    = 4'b0000;
         n++;
         tick();
      end
      bus.code_valid = 1'b0;
      chk("t3_lock_cycles", n, 10000);
      chk("t3_ready_after_lock", bus.code_ready, 1);
      occ_set(4'd9, 1'b0);
      send_code(4'b0110);
      tick();
      tick();
      chk("t3_gate_after_lock", bus.gate_open, 1);
      wait_ready();

      // set-port conflicts and fill-up
      occ_set(4'd3, 1'b0);
      occ_set(4'd3, 1'b1);
      send_code(4'b1100);
      bus.occ_set_valid = 1'b1;
      bus.occ_set_place = 4'd3;
      tick();
      chk("t5_in_check", bus.result_valid, 1);
      tick();
      bus.occ_set_valid = 1'b0;
      chk("t5_set_err_on_clear", bus.occ_set_err, 1);
      chk("t5_occ3_cleared", bus.occupancy[3], 0);
      chk("t5_free_count", bus.free_count, free_m());
      wait_ready();
      for (int i = 0; i < 16; i++) begin
         if (!occ_m[i]) occ_set(4'(i), 1'b0);
      end
      chk("t5_full_occ", bus.occupancy, 32'hFFFF);
      chk("t5_full_free", bus.free_count, 0);

      // asynchronous reset during GATE
      send_code(4'b0000);
      tick();
      tick();
      chk("t6_gate", bus.gate_open, 1);
      repeat (5) tick();
      rst_n = 1'b0;
      #2;
      occ_m = '0;
      fail_m = 0;
      chk("t6_gate_reset", bus.gate_open, 0);
      chk("t6_occ_reset", bus.occupancy, 0);
      chk("t6_free_reset", bus.free_count, 16);
      tick();
      rst_n = 1'b1;
      tick();
      chk("t6_ready", bus.code_ready, 1);
      chk("sb_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
